interval_capture: RTL and testbench

Measures the number of clock cycles between a start event and a stop event and presents the result through a valid/ready output handshake. It complements the team's countdown timer: the timer turns a value into a delay, and this block turns a delay back into a value. It sits between event sources such as timer done lines or external strobes and a consumer such as a register file or FIFO.

---
 rtl/interval_capture_pkg.sv | 16 +
 rtl/interval_capture_rise_detect.sv | 19 +
 rtl/interval_capture.sv | 115 +++++++++++
 tb/tb_interval_capture.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/interval_capture_pkg.sv
// Shared types and constants for the interval capture block.
// The state encoding is fixed so that it reads the same in waveforms and register dumps.
package interval_capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      HOLD    = 2'd2
   } state_t;

   // All-ones value of a w-bit counter: the saturation point of the interval counter.
   function automatic int unsigned sat_value(input int unsigned w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/interval_capture_rise_detect.sv
// Rising-edge detector: one history flop plus AND-NOT; output is combinational, zero latency.
// History resets to 0, so a level already high at reset release reports a rise on the first edge.
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= 1'b0;
      else     prev <= d;
   end

   assign rise = d & ~prev;

endmodule

// File: rtl/interval_capture.sv
// Counts clock edges between a start rise and a stop rise; result appears the cycle after the stop edge.
// Result is held on meas_valid until meas_ready; start rises arriving while a result is held are dropped and flagged on missed.
module interval_capture
   import interval_capture_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_in,
   input  logic             stop_in,
   input  logic             abort,
   input  logic             meas_ready,
   output logic [WIDTH-1:0] meas_val,
   output logic             meas_valid,
   output logic             meas_ovf,
   output logic             busy,
   output logic             missed
);

   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(sat_value(WIDTH));
   localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic             ovf_int;
   logic             start_rise;
   logic             stop_rise;

   rise_detect u_start_rd (
      .clk  (clk),
      .rst  (rst),
      .d    (start_in),
      .rise (start_rise)
   );

   rise_detect u_stop_rd (
      .clk  (clk),
      .rst  (rst),
      .d    (stop_in),
      .rise (stop_rise)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         ovf_int    <= 1'b0;
         meas_val   <= '0;
         meas_ovf   <= 1'b0;
         meas_valid <= 1'b0;
         busy       <= 1'b0;
         missed     <= 1'b0;
      end else begin
         missed <= 1'b0;
         case (state)
            IDLE: begin
               // A stop rise coincident with the start is ignored; start wins.
               if (start_rise) begin
                  state   <= MEASURE;
                  cnt     <= CNT_ONE;
                  ovf_int <= 1'b0;
                  busy    <= 1'b1;
               end
            end

            MEASURE: begin
               if (abort) begin
                  state <= IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (stop_rise) begin
                  state      <= HOLD;
                  meas_val   <= cnt;
                  meas_ovf   <= ovf_int;
                  meas_valid <= 1'b1;
                  busy       <= 1'b0;
                  missed     <= start_rise;
               end else if (start_rise) begin
                  cnt     <= CNT_ONE;
                  ovf_int <= 1'b0;
               end else if (cnt == CNT_MAX) begin
                  ovf_int <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            HOLD: begin
               if (meas_ready) begin
                  meas_valid <= 1'b0;
                  // Back-to-back: a start on the accepting edge begins the next measurement.
                  if (start_rise) begin
                     state   <= MEASURE;
                     cnt     <= CNT_ONE;
                     ovf_int <= 1'b0;
                     busy    <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else if (start_rise) begin
                  missed <= 1'b1;
               end
            end

            default: begin
               state      <= IDLE;
               busy       <= 1'b0;
               meas_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_interval_capture.sv
// Directed bench for interval_capture (WIDTH=8): inputs driven and outputs sampled 1ns after each rising edge.
module tb_interval_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_in;
   logic       stop_in;
   logic       abort;
   logic       meas_ready;
   logic [7:0] meas_val;
   logic       meas_valid;
   logic       meas_ovf;
   logic       busy;
   logic       missed;

   int vec_cnt = 0;
   int err_cnt = 0;
   logic missed_seen;

   interval_capture #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_in   (start_in),
      .stop_in    (stop_in),
      .abort      (abort),
      .meas_ready (meas_ready),
      .meas_val   (meas_val),
      .meas_valid (meas_valid),
      .meas_ovf   (meas_ovf),
      .busy       (busy),
      .missed     (missed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start rise sampled at edge e0, stop rise sampled at edge e(n): K = n.
   task automatic measure(input int n);
      start_in = 1'b1;
      tick();
      repeat (n - 1) tick();
      stop_in = 1'b1;
      tick();
   endtask

   task automatic idle_inputs();
      start_in = 1'b0;
      stop_in  = 1'b0;
      abort    = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; start_in = 1'b0; stop_in = 1'b0; abort = 1'b0; meas_ready = 1'b0;
      #12;
      check("rst_valid", meas_valid, 0);
      check("rst_val", meas_val, 0);
      check("rst_busy_ovf_missed", {busy, meas_ovf, missed}, 0);
      @(posedge clk); #1 rst = 1'b0;
      tick();

      // 1: K=5, busy high e0..e4, result the cycle after e5
      meas_ready = 1'b1;
      start_in = 1'b1;
      tick();
      check("t1_busy_e0", busy, 1);
      repeat (4) tick();
      check("t1_busy_e4", busy, 1);
      stop_in = 1'b1;
      tick();
      check("t1_valid", meas_valid, 1);
      check("t1_val", meas_val, 5);
      check("t1_ovf", meas_ovf, 0);
      check("t1_busy_after", busy, 0);
      tick();
      check("t1_accepted", meas_valid, 0);
      idle_inputs();

      // 2: 300-edge interval saturates
      meas_ready = 1'b0;
      measure(300);
      check("t2_valid", meas_valid, 1);
      check("t2_val", meas_val, 255);
      check("t2_ovf", meas_ovf, 1);
      check("t2_busy", busy, 0);
      meas_ready = 1'b1;
      tick();
      check("t2_accepted", meas_valid, 0);
      idle_inputs();

      // 3: start held high 20 cycles gives exactly one measurement
      missed_seen = 1'b0;
      start_in = 1'b1;
      tick();
      missed_seen |= missed;
      repeat (2) begin tick(); missed_seen |= missed; end
      stop_in = 1'b1;
      tick();
      check("t3_valid", meas_valid, 1);
      check("t3_val", meas_val, 3);
      repeat (16) begin tick(); missed_seen |= missed; end
      check("t3_no_missed", missed_seen, 0);
      check("t3_no_restart", {busy, meas_valid}, 0);
      idle_inputs();

      // 4: result 7 held with ready low, start rise during HOLD is dropped
      meas_ready = 1'b0;
      measure(7);
      check("t4_val", meas_val, 7);
      start_in = 1'b0;
      tick();
      check("t4_no_missed_yet", missed, 0);
      start_in = 1'b1;
      tick();
      check("t4_missed_pulse", missed, 1);
      check("t4_valid_held", meas_valid, 1);
      tick();
      check("t4_missed_one_cycle", missed, 0);
      tick();
      check("t4_val_held", meas_val, 7);
      check("t4_valid_held2", meas_valid, 1);
      meas_ready = 1'b1;
      tick();
      check("t4_accept", meas_valid, 0);
      check("t4_idle", busy, 0);
      idle_inputs();

      // 5a: abort 4 edges in, later stop ignored
      meas_ready = 1'b1;
      start_in = 1'b1;
      tick();
      repeat (3) tick();
      abort = 1'b1;
      tick();
      check("t5_abort_busy", busy, 0);
      check("t5_abort_valid", meas_valid, 0);
      abort = 1'b0;
      stop_in = 1'b1;
      tick();
      tick();
      check("t5_stop_ignored", {busy, meas_valid}, 0);
      idle_inputs();

      // 5b: reset while holding a result clears everything immediately
      meas_ready = 1'b0;
      measure(4);
      check("t5_hold_valid", meas_valid, 1);
      #1 rst = 1'b1;
      #1;
      check("t5_rst_valid", meas_valid, 0);
      check("t5_rst_val", meas_val, 0);
      check("t5_rst_flags", {meas_ovf, busy, missed}, 0);
      start_in = 1'b0; stop_in = 1'b0;
      @(negedge clk) rst = 1'b0;
      tick();

      // 6: back-to-back accept and start on the same edge
      meas_ready = 1'b0;
      measure(3);
      check("t6_first_val", meas_val, 3);
      start_in = 1'b0;
      stop_in = 1'b0;
      tick();
      start_in = 1'b1;
      meas_ready = 1'b1;
      tick();
      check("t6_b2b_busy", busy, 1);
      check("t6_b2b_valid", meas_valid, 0);
      check("t6_b2b_missed", missed, 0);
      meas_ready = 1'b0;
      tick();
      stop_in = 1'b1;
      tick();
      check("t6_second_valid", meas_valid, 1);
      check("t6_second_val", meas_val, 2);
      check("t6_missed", missed, 0);
      meas_ready = 1'b1;
      tick();
      idle_inputs();

      // 7: second start rise restarts the count
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      tick();
      tick();
      start_in = 1'b1;
      tick();
      check("t7_restart_missed", missed, 0);
      check("t7_busy", busy, 1);
      repeat (3) tick();
      stop_in = 1'b1;
      tick();
      check("t7_valid", meas_valid, 1);
      check("t7_val", meas_val, 4);
      check("t7_ovf", meas_ovf, 0);
      idle_inputs();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
